// File: rtl/writeback_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : writeback_unit_if
// Brief    : Bundle of the memory-stage handshake, the load response and the
//            register-file write port seen by writeback_unit.
// Revision : 1.0 - initial release
// ============================================================================
interface writeback_unit_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter int RWIDTH = 5
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [AWIDTH-1:0] pc_i;
  logic [DWIDTH-1:0] alu_res_i;
  logic [1:0]        wbsel_i;
  logic [2:0]        funct3_i;
  logic [RWIDTH-1:0] rd_i;
  logic              regwen_i;
  logic              mem_rsp_valid_i;
  logic [DWIDTH-1:0] mem_rsp_data_i;
  logic              rd_we_o;
  logic [RWIDTH-1:0] rd_addr_o;
  logic [DWIDTH-1:0] rd_data_o;
  logic              timeout_o;
  logic [31:0]       retired_o;

  // Write-back unit side
  modport slave (
    input  in_valid_i, pc_i, alu_res_i, wbsel_i, funct3_i, rd_i, regwen_i,
    input  mem_rsp_valid_i, mem_rsp_data_i,
    output in_ready_o, rd_we_o, rd_addr_o, rd_data_o, timeout_o, retired_o
  );

  // Memory stage / register file side
  modport master (
    output in_valid_i, pc_i, alu_res_i, wbsel_i, funct3_i, rd_i, regwen_i,
    output mem_rsp_valid_i, mem_rsp_data_i,
    input  in_ready_o, rd_we_o, rd_addr_o, rd_data_o, timeout_o, retired_o
  );
endinterface
`default_nettype wire

// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
// Module   : writeback_unit
// Brief    : Handshaked write-back stage. Selects ALU / load / PC+4 / no
//            write, waits for load responses with a bounded timeout, drives a
//            registered register-file write port and counts retirements.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_unit #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 32,
  parameter int RWIDTH   = 5,
  parameter int MAX_WAIT = 15
) (
  input  wire logic       clk,
  input  wire logic       reset,
  writeback_unit_if.slave bus
);
  localparam int OFFW = $clog2(DWIDTH / 8);
  localparam int CW   = 8;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [RWIDTH-1:0] r_rd;
  logic              r_regwen;
  logic [2:0]        r_funct3;
  logic [OFFW-1:0]   r_off;
  logic              r_rd_we;
  logic [RWIDTH-1:0] r_rd_addr;
  logic [DWIDTH-1:0] r_rd_data;
  logic              r_timeout;
  logic [31:0]       r_retired;

  logic              w_accept;
  logic              w_imm_we;
  logic              w_load_we;
  logic [AWIDTH-1:0] w_pc4;
  logic [DWIDTH-1:0] w_imm_data;
  logic [DWIDTH-1:0] w_load_data;

  // Extract and extend the addressed field of a raw aligned memory word;
  // the byte offset is masked down to the natural alignment of each size.
  function automatic logic [DWIDTH-1:0] fmt_load(
    input logic [2:0]        f3,
    input logic [OFFW-1:0]   off,
    input logic [DWIDTH-1:0] word
  );
    logic [OFFW-1:0]   amt;
    logic [DWIDTH-1:0] sh;
    case (f3[1:0])
      2'b00:   amt = off;
      2'b01:   amt = off & ~OFFW'(1);
      2'b10:   amt = off & ~OFFW'(3);
      default: amt = '0;
    endcase
    sh = word >> {amt, 3'b000};
    case (f3)
      3'b000:  fmt_load = DWIDTH'($signed(sh[7:0]));
      3'b001:  fmt_load = DWIDTH'($signed(sh[15:0]));
      3'b010:  fmt_load = DWIDTH'($signed(sh[31:0]));
      3'b100:  fmt_load = DWIDTH'(sh[7:0]);
      3'b101:  fmt_load = DWIDTH'(sh[15:0]);
      3'b110:  fmt_load = DWIDTH'(sh[31:0]);
      default: fmt_load = sh;
    endcase
  endfunction

  assign bus.in_ready_o = (r_state == IDLE);
  assign bus.rd_we_o    = r_rd_we;
  assign bus.rd_addr_o  = r_rd_addr;
  assign bus.rd_data_o  = r_rd_data;
  assign bus.timeout_o  = r_timeout;
  assign bus.retired_o  = r_retired;

  assign w_accept    = bus.in_valid_i && (r_state == IDLE);
  assign w_pc4       = bus.pc_i + AWIDTH'(4);
  assign w_imm_we    = bus.regwen_i && (bus.rd_i != '0) && (bus.wbsel_i != 2'b11);
  assign w_load_we   = r_regwen && (r_rd != '0);
  assign w_load_data = fmt_load(r_funct3, r_off, bus.mem_rsp_data_i);

  // Write-back value for the single-cycle (non-load) selections
  always_comb begin
    w_imm_data = '0;
    case (bus.wbsel_i)
      2'b00:   w_imm_data = bus.alu_res_i;
      2'b10:   w_imm_data = DWIDTH'(w_pc4);
      default: w_imm_data = '0;
    endcase
  end

  // Control FSM, load bookkeeping and registered write port / counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_rd      <= '0;
      r_regwen  <= 1'b0;
      r_funct3  <= '0;
      r_off     <= '0;
      r_rd_we   <= 1'b0;
      r_rd_addr <= '0;
      r_rd_data <= '0;
      r_timeout <= 1'b0;
      r_retired <= '0;
    end else begin
      r_rd_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (bus.wbsel_i == 2'b01) begin
              r_rd     <= bus.rd_i;
              r_regwen <= bus.regwen_i;
              r_funct3 <= bus.funct3_i;
              r_off    <= bus.alu_res_i[OFFW-1:0];
              r_cnt    <= '0;
              r_state  <= WAIT_MEM;
            end else begin
              r_rd_we <= w_imm_we;
              if (w_imm_we) begin
                r_rd_addr <= bus.rd_i;
                r_rd_data <= w_imm_data;
              end
              r_retired <= r_retired + 32'd1;
            end
          end
        end
        WAIT_MEM: begin
          // A response on the final allowed cycle still beats the timeout
          if (bus.mem_rsp_valid_i) begin
            r_rd_we <= w_load_we;
            if (w_load_we) begin
              r_rd_addr <= r_rd;
              r_rd_data <= w_load_data;
            end
            r_retired <= r_retired + 32'd1;
            r_state   <= IDLE;
          end else if (r_cnt == CW'(MAX_WAIT - 1)) begin
            r_timeout <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_unit
// Brief    : Self-checking bench for writeback_unit: directed scenarios then
//            randomized traffic against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_unit;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int RW = 5;
  localparam int MW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  writeback_unit_if #(.DWIDTH(DW), .AWIDTH(AW), .RWIDTH(RW)) bus ();

  writeback_unit #(.DWIDTH(DW), .AWIDTH(AW), .RWIDTH(RW), .MAX_WAIT(MW)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state: a pending load is described by its latched fields
  // and the last cycle on which a response may still arrive.
  bit          m_busy     = 1'b0;
  int          m_deadline = 0;
  logic [4:0]  m_rd       = '0;
  bit          m_rw       = 1'b0;
  logic [2:0]  m_f3       = '0;
  logic [1:0]  m_off      = '0;
  bit          e_we       = 1'b0;
  logic [4:0]  e_addr     = '0;
  logic [31:0] e_data     = '0;
  bit          e_to       = 1'b0;
  logic [31:0] e_ret      = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * int'(off))) & 32'hFF;
    h = (w >> (16 * (int'(off) / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic drive(input bit v, input logic [1:0] ws, input logic [2:0] f3,
                       input logic [4:0] rd, input bit rw, input logic [31:0] pc,
                       input logic [31:0] alu, input bit rv, input logic [31:0] rdata);
    bus.in_valid_i      = v;
    bus.wbsel_i         = ws;
    bus.funct3_i        = f3;
    bus.rd_i            = rd;
    bus.regwen_i        = rw;
    bus.pc_i            = pc;
    bus.alu_res_i       = alu;
    bus.mem_rsp_valid_i = rv;
    bus.mem_rsp_data_i  = rdata;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 3'd0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
  endtask

  // One clock: check readiness, advance the model on the edge, check outputs.
  task automatic step();
    check("in_ready", {63'd0, bus.in_ready_o}, {63'd0, !m_busy});
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_busy = 0; e_we = 0; e_addr = '0; e_data = '0; e_to = 0; e_ret = '0;
    end else begin
      e_we = 0;
      if (!m_busy) begin
        if (bus.in_valid_i) begin
          if (bus.wbsel_i == 2'b01) begin
            m_busy     = 1;
            m_deadline = cyc + MW;
            m_rd       = bus.rd_i;
            m_rw       = bus.regwen_i;
            m_f3       = bus.funct3_i;
            m_off      = bus.alu_res_i[1:0];
          end else begin
            if (bus.regwen_i && bus.rd_i != 0 && bus.wbsel_i != 2'b11) begin
              e_we   = 1;
              e_addr = bus.rd_i;
              e_data = (bus.wbsel_i == 2'b00) ? bus.alu_res_i : bus.pc_i + 32'd4;
            end
            e_ret = e_ret + 1;
          end
        end
      end else if (bus.mem_rsp_valid_i) begin
        if (m_rw && m_rd != 0) begin
          e_we   = 1;
          e_addr = m_rd;
          e_data = ref_load(m_f3, m_off, bus.mem_rsp_data_i);
        end
        e_ret  = e_ret + 1;
        m_busy = 0;
      end else if (cyc == m_deadline) begin
        e_to   = 1;
        m_busy = 0;
      end
    end
    #1;
    check("rd_we",   {63'd0, bus.rd_we_o},   {63'd0, e_we});
    check("rd_addr", {59'd0, bus.rd_addr_o}, {59'd0, e_addr});
    check("rd_data", {32'd0, bus.rd_data_o}, {32'd0, e_data});
    check("timeout", {63'd0, bus.timeout_o}, {63'd0, e_to});
    check("retired", {32'd0, bus.retired_o}, {32'd0, e_ret});
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #1;
    step();
    step();
    rst_n = 1'b1;
    check("rst_ready", {63'd0, bus.in_ready_o}, 64'd1);
    check("rst_data",  {32'd0, bus.rd_data_o},  64'd0);

    // ALU result
    drive(1, 2'b00, 3'd0, 5'd5, 1, 32'h0, 32'h1234, 0, 32'h0);
    step();
    check("alu_data", {32'd0, bus.rd_data_o}, 64'h1234);
    check("alu_ret",  {32'd0, bus.retired_o}, 64'd1);

    // JAL link value, then the same with rd=0
    drive(1, 2'b10, 3'd0, 5'd1, 1, 32'h100, 32'h0, 0, 32'h0);
    step();
    check("jal_data", {32'd0, bus.rd_data_o}, 64'h104);
    drive(1, 2'b10, 3'd0, 5'd0, 1, 32'h100, 32'h0, 0, 32'h0);
    step();
    check("jal_rd0_we",  {63'd0, bus.rd_we_o},   64'd0);
    check("jal_rd0_ret", {32'd0, bus.retired_o}, 64'd3);

    // LB at byte 3 and LHU at byte 2
    drive(1, 2'b01, 3'd0, 5'd7, 1, 32'h0, 32'h1003, 0, 32'h0);
    step();
    drive(0, 2'b00, 3'd0, 5'd0, 0, 32'h0, 32'h0, 1, 32'h80FF_7F01);
    step();
    check("lb_data", {32'd0, bus.rd_data_o}, 64'hFFFF_FF80);
    drive(1, 2'b01, 3'd5, 5'd8, 1, 32'h0, 32'h1002, 0, 32'h0);
    step();
    drive(0, 2'b00, 3'd0, 5'd0, 0, 32'h0, 32'h0, 1, 32'h80FF_7F01);
    step();
    check("lhu_data", {32'd0, bus.rd_data_o}, 64'h0000_80FF);

    // Response three cycles after accept, then an ALU op immediately
    drive(1, 2'b01, 3'd2, 5'd9, 1, 32'h0, 32'h2000, 0, 32'h0);
    step();
    idle(); step();
    idle(); step();
    drive(0, 2'b00, 3'd0, 5'd0, 0, 32'h0, 32'h0, 1, 32'hCAFE_F00D);
    step();
    check("lat_data", {32'd0, bus.rd_data_o}, 64'hCAFE_F00D);
    drive(1, 2'b00, 3'd0, 5'd10, 1, 32'h0, 32'h55, 0, 32'h0);
    step();
    check("lat_next", {32'd0, bus.rd_data_o}, 64'h55);

    // Response on the last allowed cycle wins over the timeout
    drive(1, 2'b01, 3'd2, 5'd11, 1, 32'h0, 32'h3000, 0, 32'h0);
    step();
    for (int i = 0; i < MW - 1; i++) begin idle(); step(); end
    drive(0, 2'b00, 3'd0, 5'd0, 0, 32'h0, 32'h0, 1, 32'h1357_9BDF);
    step();
    check("edge_we", {63'd0, bus.rd_we_o},   64'd1);
    check("edge_to", {63'd0, bus.timeout_o}, 64'd0);

    // No response at all: timeout, no write, no retire
    drive(1, 2'b01, 3'd2, 5'd12, 1, 32'h0, 32'h4000, 0, 32'h0);
    step();
    for (int i = 0; i < MW; i++) begin idle(); step(); end
    check("to_flag", {63'd0, bus.timeout_o},  64'd1);
    check("to_rdy",  {63'd0, bus.in_ready_o}, 64'd1);

    // Reset while waiting drops the pending load
    drive(1, 2'b01, 3'd2, 5'd13, 1, 32'h0, 32'h5000, 0, 32'h0);
    step();
    idle(); step();
    drive(0, 2'b00, 3'd0, 5'd0, 0, 32'h0, 32'h0, 1, 32'hDEAD_BEEF);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rstw_rdy", {63'd0, bus.in_ready_o}, 64'd1);
    step();
    check("rstw_we",  {63'd0, bus.rd_we_o},   64'd0);
    check("rstw_ret", {32'd0, bus.retired_o}, 64'd0);

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom_range(0, 5) != 0,
            $urandom, $urandom, $urandom_range(0, 9) < 3, $urandom);
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/writeback_unit.md
# writeback_unit

Pipelined, handshaked successor to the combinational write-back select stage. It accepts one retiring instruction per cycle from the memory stage and selects its write-back value: ALU result, formatted load data, PC+4 or none. It waits a variable number of cycles for load responses, with a bounded timeout. It drives a registered register-file write port and counts retired instructions. It sits between the memory stage and the register file.

## Interface
- DWIDTH, 32: data width; legal values 32 or 64.
- AWIDTH, 32: PC width.
- RWIDTH, 5: register index width.
- MAX_WAIT, 15: maximum WAIT_MEM cycles before timeout; range 1..255.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; when sampled low, all state and outputs are forced to reset values.
- in_valid_i  in  1  memory stage presents an instruction.
- in_ready_o  out  1  unit can accept; equals (state==IDLE).
- pc_i  in  AWIDTH  instruction PC.
- alu_res_i  in  DWIDTH  ALU result; for loads, the byte address.
- wbsel_i  in  2  00 ALU, 01 load, 10 PC+4, 11 no write.
- funct3_i  in  3  load format code.
- rd_i  in  RWIDTH  destination register.
- regwen_i  in  1  instruction writes rd.
- mem_rsp_valid_i  in  1  load data valid this cycle.
- mem_rsp_data_i  in  DWIDTH  raw aligned memory word.
- rd_we_o  out  1  register write enable; reset 0.
- rd_addr_o  out  RWIDTH  write index; reset 0.
- rd_data_o  out  DWIDTH  write data; reset 0.
- timeout_o  out  1  sticky flag; set when a load response never arrives; reset 0.
- retired_o  out  32  count of completed instructions; wraps modulo 2^32; reset 0.

## Operation
- States: IDLE, WAIT_MEM.
- An instruction is accepted when in_valid_i && in_ready_o.
- **IDLE, accept with wbsel ≠ 01:**
  - Data is alu_res_i for 00.
  - Data is pc_i+4 for 10. The sum is truncated to AWIDTH, then zero-extended or truncated to DWIDTH.
  - Data is 0 for 11.
  - Next cycle: rd_we_o = regwen_i && rd_i≠0 && wbsel_i≠11, with rd_addr_o/rd_data_o registered.
  - retired_o increments by 1.
  - State stays IDLE.
- **IDLE, accept with wbsel = 01:**
  - Latch rd_i, regwen_i, funct3_i and the address low bits.
  - Clear the wait counter and go to WAIT_MEM.
- **WAIT_MEM:**
  - in_ready_o = 0. The counter increments every cycle that mem_rsp_valid_i is low.
  - When mem_rsp_valid_i is high, format the data and register it to the write port (gated as above).
  - retired_o increments by 1 and the state returns to IDLE.
  - If the counter reaches MAX_WAIT with no response, set timeout_o, perform no write and no retire increment, and return to IDLE.
  - A response in the same cycle the counter hits MAX_WAIT wins: the write happens and timeout_o is not set.
- mem_rsp_valid_i in IDLE is ignored.
- **Load formatting:** off = alu_res_i[log2(DWIDTH/8)-1:0] bytes.
  - 000 LB: sign-extended byte at off.
  - 001 LH: sign-extended half at off&~1.
  - 010 LW: word at off&~3, sign-extended to DWIDTH.
  - 100 LBU / 101 LHU: zero-extended.
  - 110 LWU: zero-extended word (meaningful for DWIDTH=64; equals LW when DWIDTH=32).
  - 011 LD: full word.
  - 111: full word.
  - Misalignment is not checked; the low address bits are masked as stated.
- rd_we_o is a single-cycle pulse per write. It is 0 in every cycle with no write.
- rd_addr_o/rd_data_o hold their last values when rd_we_o = 0.

## Timing
- Non-load: accepted at cycle N, write visible at N+1. Back-to-back accepts every cycle give one write per cycle.
- Load: accepted at N, WAIT_MEM from N+1, response earliest at N+1. A response at M gives the write at M+1, and in_ready_o is high at M+1.
- Timeout: accepted at N, counter reaches MAX_WAIT at N+MAX_WAIT. timeout_o is high from N+MAX_WAIT+1 and IDLE is reached at N+MAX_WAIT+1.
- Reset low mid-WAIT_MEM: the pending load is dropped, state goes to IDLE, and all outputs go to 0 in the next cycle. in_ready_o is 1 in the first cycle after reset is high.

## Test plan
- ALU op: rd=5, alu=0x1234, wbsel=00 at cycle N -> rd_we_o=1, rd_addr_o=5, rd_data_o=0x1234 at N+1; retired_o=1.
- JAL: pc=0x100, wbsel=10, rd=1 -> rd_data_o=0x104 at N+1. Same instruction with rd=0 -> rd_we_o=0, retired_o still increments.
- LB/LHU: addr=0x...3, data=0x80FF7F01, funct3=000 -> 0xFFFFFF80. Addr=0x...2, funct3=101 -> 0x000080FF.
- Load latency: response 3 cycles after accept -> in_ready_o low 3 cycles, write on response+1, a new ALU op is accepted that same cycle.
- Timeout: MAX_WAIT=4, no response -> timeout_o=1 at N+5, no write, retired_o unchanged. A response exactly at N+4 -> write happens, timeout_o=0.
- Reset low during WAIT_MEM, then a response arrives -> no write, outputs 0, in_ready_o=1 after reset release.
